// File: rtl/eth_rx_ring_buf.sv
// rtl/eth_rx_ring_buf.sv - multi-slot Ethernet RX frame ring buffer
// Stores whole frames from the byte stream into NSLOTS slots; the core reads and releases the oldest.
module eth_rx_ring_buf #(
   parameter int NSLOTS = 4,
   parameter int SLOT_BYTES = 2048,
   localparam int LEN_W = $clog2(SLOT_BYTES) + 1,
   localparam int ADDR_W = $clog2(SLOT_BYTES) - 2,
   localparam int CNT_W = $clog2(NSLOTS) + 1
) (
   input  logic              clk_rmii,
   input  logic              rst,
   input  logic [7:0]        s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tuser,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data,
   input  logic              release_head,
   input  logic              irq_en,
   output logic [LEN_W-1:0]  head_len,
   output logic [1:0]        head_err,
   output logic [CNT_W-1:0]  count,
   output logic [15:0]       drop_cnt,
   output logic              irq
);
   localparam int SLOT_W = $clog2(NSLOTS);
   localparam int DEPTH = NSLOTS * SLOT_BYTES / 4;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NSLOTS);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SLOT_BYTES);

   typedef enum logic [1:0] {SKIP, IDLE, RECV, DROP} state_t;
   state_t state, state_nxt;

   logic [3:0][7:0]   mem [DEPTH];
   logic [LEN_W-1:0]  len_mem [NSLOTS];
   logic [1:0]        err_mem [NSLOTS];
   logic [SLOT_W-1:0] head, tail;
   logic [LEN_W-1:0]  p;

   logic              full, rel;
   logic              wr_en, commit, commit_trunc, drop_inc;
   logic [LEN_W-1:0]  wr_pos, commit_len;

   assign full = (count == FULL);
   assign rel  = release_head && (count != '0);

   always_ff @(posedge clk_rmii) begin
      if (rst) state <= SKIP;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SKIP:       if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
         IDLE:       if (s_axis_tvalid && !s_axis_tlast) state_nxt = full ? DROP : RECV;
         RECV, DROP: if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
         default:    state_nxt = SKIP;
      endcase
   end

   // Once p saturates at SLOT_BYTES every further byte is discarded and marks the frame truncated.
   always_comb begin
      wr_en        = 1'b0;
      wr_pos       = '0;
      commit       = 1'b0;
      commit_len   = '0;
      commit_trunc = 1'b0;
      drop_inc     = 1'b0;
      case (state)
         IDLE: begin
            if (s_axis_tvalid) begin
               if (full) begin
                  drop_inc = 1'b1;
               end else begin
                  wr_en      = 1'b1;
                  commit     = s_axis_tlast;
                  commit_len = LEN_W'(1);
               end
            end
         end
         RECV: begin
            if (s_axis_tvalid) begin
               wr_pos       = p;
               wr_en        = (p < MAX_LEN);
               commit       = s_axis_tlast;
               commit_trunc = (p >= MAX_LEN);
               commit_len   = (p < MAX_LEN) ? p + LEN_W'(1) : MAX_LEN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_rmii) begin
      if (wr_en)
         mem[{tail, wr_pos[LEN_W-2:2]}][wr_pos[1:0]] <= s_axis_tdata;
      if (commit) begin
         len_mem[tail] <= commit_len;
         err_mem[tail] <= {commit_trunc, s_axis_tuser};
      end
   end

   always_ff @(posedge clk_rmii) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[{head, rd_addr}];
   end

   always_ff @(posedge clk_rmii) begin
      if (rst) begin
         p        <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         drop_cnt <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_en)  p    <= wr_pos + LEN_W'(1);
         if (commit) tail <= tail + SLOT_W'(1);
         if (rel)    head <= head + SLOT_W'(1);
         if (commit && !rel)      count <= count + CNT_W'(1);
         else if (rel && !commit) count <= count - CNT_W'(1);
         if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         irq <= (count != '0) && irq_en;
      end
   end

   assign head_len = (count == '0) ? '0 : len_mem[head];
   assign head_err = (count == '0) ? 2'b00 : err_mem[head];

endmodule

// File: tb/tb_eth_rx_ring_buf.sv
// tb/tb_eth_rx_ring_buf.sv - directed self-checking bench for eth_rx_ring_buf
// After every reset the receiver waits for a frame boundary, so a one-byte flush frame is fed first.
module tb_eth_rx_ring_buf;
   logic        clk;
   logic        rst;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tlast;
   logic        tuser;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [31:0] rd_data;
   logic        release_head;
   logic        irq_en;
   logic [11:0] head_len;
   logic [1:0]  head_err;
   logic [2:0]  count;
   logic [15:0] drop_cnt;
   logic        irq;

   int compared = 0;
   int mismatched = 0;

   eth_rx_ring_buf #(.NSLOTS(4), .SLOT_BYTES(2048)) dut (
      .clk_rmii(clk),
      .rst(rst),
      .s_axis_tdata(tdata),
      .s_axis_tvalid(tvalid),
      .s_axis_tlast(tlast),
      .s_axis_tuser(tuser),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .release_head(release_head),
      .irq_en(irq_en),
      .head_len(head_len),
      .head_err(head_err),
      .count(count),
      .drop_cnt(drop_cnt),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int n, input logic [7:0] base, input logic last,
                       input logic user, input logic rel_last);
      for (int i = 0; i < n; i++) begin
         tdata        = base + 8'(i);
         tvalid       = 1'b1;
         tlast        = last && (i == n - 1);
         tuser        = user && (i == n - 1);
         release_head = rel_last && (i == n - 1);
         tick();
      end
      tvalid       = 1'b0;
      tlast        = 1'b0;
      tuser        = 1'b0;
      release_head = 1'b0;
   endtask

   task automatic rd(input logic [8:0] addr, input logic [31:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = addr;
      tick();
      rd_en   = 1'b0;
      check(tag, rd_data, exp);
   endtask

   task automatic rel();
      release_head = 1'b1;
      tick();
      release_head = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      rd_en = 1'b0; rd_addr = '0; release_head = 1'b0; irq_en = 1'b1;
      do_reset();
      check("rst_count", 32'(count), 32'd0);
      check("rst_head_len", 32'(head_len), 32'd0);
      check("rst_head_err", 32'(head_err), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);

      send(1, 8'hEE, 1'b1, 1'b0, 1'b0);
      check("skip_count", 32'(count), 32'd0);

      // 64-byte frame 00..3F
      send(64, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t1_count", 32'(count), 32'd1);
      check("t1_head_len", 32'(head_len), 32'd64);
      check("t1_head_err", 32'(head_err), 32'd0);
      tick();
      check("t1_irq", 32'(irq), 32'd1);
      rd(9'd0, 32'h03020100, "t1_word0");
      rd(9'd15, 32'h3F3E3D3C, "t1_word15");
      tick();
      check("t1_rd_hold", rd_data, 32'h3F3E3D3C);
      rel();
      check("t1_rel_count", 32'(count), 32'd0);
      tick();
      check("t1_irq_clear", 32'(irq), 32'd0);

      // five 60-byte frames into four slots
      for (int k = 0; k < 5; k++)
         send(60, 8'(k * 16), 1'b1, 1'b0, 1'b0);
      check("t2_count", 32'(count), 32'd4);
      check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
      for (int k = 0; k < 4; k++) begin
         b = 8'(k * 16);
         check("t2_head_len", 32'(head_len), 32'd60);
         rd(9'd0, {b + 8'd3, b + 8'd2, b + 8'd1, b}, "t2_word0");
         rel();
      end
      check("t2_count_empty", 32'(count), 32'd0);
      tick();
      check("t2_irq", 32'(irq), 32'd0);

      // oversize frame then a normal one
      send(3000, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t3_head_len", 32'(head_len), 32'd2048);
      check("t3_head_err", 32'(head_err), 32'd2);
      rd(9'd511, 32'hFFFEFDFC, "t3_last_word");
      send(64, 8'h80, 1'b1, 1'b0, 1'b0);
      check("t3_count", 32'(count), 32'd2);
      rel();
      check("t3_next_len", 32'(head_len), 32'd64);
      check("t3_next_err", 32'(head_err), 32'd0);
      rd(9'd0, 32'h83828180, "t3_next_word0");
      rd(9'd15, 32'hBFBEBDBC, "t3_next_word15");
      rel();
      check("t3_empty", 32'(count), 32'd0);

      // bad-FCS frame, then commit with simultaneous release
      send(10, 8'h10, 1'b1, 1'b1, 1'b0);
      check("t4_count", 32'(count), 32'd1);
      check("t4_head_err", 32'(head_err), 32'd1);
      check("t4_head_len", 32'(head_len), 32'd10);
      send(20, 8'h20, 1'b1, 1'b0, 1'b1);
      check("t4_count_same", 32'(count), 32'd1);
      check("t4_new_len", 32'(head_len), 32'd20);
      check("t4_new_err", 32'(head_err), 32'd0);
      rd_en = 1'b1; rd_addr = 9'd0; release_head = 1'b1;
      tick();
      rd_en = 1'b0; release_head = 1'b0;
      check("t4_read_in_release", rd_data, 32'h23222120);
      check("t4_count_zero", 32'(count), 32'd0);

      // reset in the middle of a frame
      send(20, 8'h00, 1'b0, 1'b0, 1'b0);
      do_reset();
      check("t5_drop_cleared", 32'(drop_cnt), 32'd0);
      send(44, 8'd20, 1'b1, 1'b0, 1'b0);
      check("t5_skipped", 32'(count), 32'd0);
      send(64, 8'h40, 1'b1, 1'b0, 1'b0);
      check("t5_count", 32'(count), 32'd1);
      check("t5_head_len", 32'(head_len), 32'd64);
      rd(9'd0, 32'h43424140, "t5_word0");
      irq_en = 1'b0;
      tick();
      check("t5_irq_masked", 32'(irq), 32'd0);
      irq_en = 1'b1;
      tick();
      check("t5_irq_enabled", 32'(irq), 32'd1);

      // release on empty ring, then a single-byte frame
      rel();
      check("t6_count_zero", 32'(count), 32'd0);
      rel();
      check("t6_empty_release", 32'(count), 32'd0);
      check("t6_empty_len", 32'(head_len), 32'd0);
      send(1, 8'hA5, 1'b1, 1'b0, 1'b0);
      check("t6_count", 32'(count), 32'd1);
      check("t6_head_len", 32'(head_len), 32'd1);
      check("t6_head_err", 32'(head_err), 32'd0);
      rd_en = 1'b1; rd_addr = 9'd0;
      tick();
      rd_en = 1'b0;
      check("t6_byte", 32'(rd_data[7:0]), 32'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
